// File: rtl/inputconditioner_pkg.sv
// Shared defaults and parameter sanity checks for the input conditioner bank.
package inputconditioner_pkg;

  localparam int unsigned DEF_WAITTIME     = 3;
  localparam int unsigned DEF_COUNTERWIDTH = 3;
  localparam int unsigned DEF_SYNCSTAGES   = 2;

  // True when a COUNTERWIDTH-bit counter can reach WAITTIME without wrapping.
  function automatic bit counter_fits(input int unsigned cw, input int unsigned wt);
    return (64'(1) << cw) > 64'(wt);
  endfunction

endpackage

// File: rtl/conditioner_channel.sv
// One channel: synchronizer, debounce counter, edge pulses and sticky edge flags.
module conditioner_channel
  import inputconditioner_pkg::*;
#(
  parameter int unsigned WAITTIME     = DEF_WAITTIME,
  parameter int unsigned COUNTERWIDTH = DEF_COUNTERWIDTH,
  parameter int unsigned SYNCSTAGES   = DEF_SYNCSTAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic noisysignal,
  input  logic clearflags,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge,
  output logic posflag,
  output logic negflag
);

  localparam logic [COUNTERWIDTH-1:0] WAIT_MAX = COUNTERWIDTH'(WAITTIME);

  logic [SYNCSTAGES-1:0]   sync_q, sync_d;
  logic [COUNTERWIDTH-1:0] count_q, count_d;
  logic cond_q, cond_d;
  logic pos_q, pos_d;
  logic neg_q, neg_d;
  logic pflag_q, pflag_d;
  logic nflag_q, nflag_d;
  logic synced;

  assign synced = sync_q[SYNCSTAGES-1];

  // Next state: shift synchronizer, count while the synced level disagrees, commit at WAITTIME.
  always_comb begin
    sync_d  = {sync_q[SYNCSTAGES-2:0], noisysignal};
    count_d = '0;
    cond_d  = cond_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    if (synced != cond_q) begin
      if (count_q == WAIT_MAX) begin
        cond_d = synced;
        pos_d  = synced;
        neg_d  = ~synced;
      end else begin
        count_d = count_q + COUNTERWIDTH'(1);
      end
    end
    // The registered pulse sets the flag, so a coincident clear loses.
    pflag_d = pos_q | (pflag_q & ~clearflags);
    nflag_d = neg_q | (nflag_q & ~clearflags);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      count_q <= '0;
      cond_q  <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      pflag_q <= 1'b0;
      nflag_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      count_q <= count_d;
      cond_q  <= cond_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      pflag_q <= pflag_d;
      nflag_q <= nflag_d;
    end
  end

  assign conditioned  = cond_q;
  assign positiveedge = pos_q;
  assign negativeedge = neg_q;
  assign posflag      = pflag_q;
  assign negflag      = nflag_q;

endmodule

// File: rtl/input_conditioner_bank.sv
// Bank of independent input conditioners with a combined any-edge indicator.
module input_conditioner_bank
  import inputconditioner_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned WAITTIME     = DEF_WAITTIME,
  parameter int unsigned COUNTERWIDTH = DEF_COUNTERWIDTH,
  parameter int unsigned SYNCSTAGES   = DEF_SYNCSTAGES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisysignal,
  input  logic [CHANNELS-1:0] clearflags,
  output logic [CHANNELS-1:0] conditioned,
  output logic [CHANNELS-1:0] positiveedge,
  output logic [CHANNELS-1:0] negativeedge,
  output logic [CHANNELS-1:0] posflag,
  output logic [CHANNELS-1:0] negflag,
  output logic                anyedge
);

  // Reject parameter sets the channel logic cannot honour.
  if (!counter_fits(COUNTERWIDTH, WAITTIME)) begin : g_bad_width
    $error("COUNTERWIDTH too small: 2**COUNTERWIDTH must exceed WAITTIME");
  end
  if (WAITTIME < 1) begin : g_bad_wait
    $error("WAITTIME must be at least 1");
  end
  if (SYNCSTAGES < 2 || SYNCSTAGES > 4) begin : g_bad_sync
    $error("SYNCSTAGES must be in 2..4");
  end
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_chan
    $error("CHANNELS must be in 1..32");
  end

  // One conditioner per channel.
  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    conditioner_channel #(
      .WAITTIME    (WAITTIME),
      .COUNTERWIDTH(COUNTERWIDTH),
      .SYNCSTAGES  (SYNCSTAGES)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .noisysignal (noisysignal[i]),
      .clearflags  (clearflags[i]),
      .conditioned (conditioned[i]),
      .positiveedge(positiveedge[i]),
      .negativeedge(negativeedge[i]),
      .posflag     (posflag[i]),
      .negflag     (negflag[i])
    );
  end

  // Only cross-channel logic: any pulse on any channel this cycle.
  assign anyedge = |(positiveedge | negativeedge);

endmodule

// File: tb/tb_input_conditioner_bank.sv
// Directed cycle-by-cycle vectors for the default bank plus an 8-channel latency check.
module tb_input_conditioner_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic       rst_a;
  logic [3:0] noisy_a, clr_a, cond_a, pe_a, ne_a, pf_a, nf_a;
  logic       any_a;

  input_conditioner_bank u_dut_a (
    .clk(clk), .reset(rst_a), .noisysignal(noisy_a), .clearflags(clr_a),
    .conditioned(cond_a), .positiveedge(pe_a), .negativeedge(ne_a),
    .posflag(pf_a), .negflag(nf_a), .anyedge(any_a)
  );

  // Wide, slower instance.
  logic       rst_b;
  logic [7:0] noisy_b, clr_b, cond_b, pe_b, ne_b, pf_b, nf_b;
  logic       any_b;

  input_conditioner_bank #(
    .CHANNELS(8), .WAITTIME(5), .COUNTERWIDTH(3), .SYNCSTAGES(2)
  ) u_dut_b (
    .clk(clk), .reset(rst_b), .noisysignal(noisy_b), .clearflags(clr_b),
    .conditioned(cond_b), .positiveedge(pe_b), .negativeedge(ne_b),
    .posflag(pf_b), .negflag(nf_b), .anyedge(any_b)
  );

  typedef struct {
    int         n;
    logic       rst;
    logic [3:0] noisy;
    logic [3:0] clr;
    logic [3:0] cond;
    logic [3:0] pos;
    logic [3:0] neg;
    logic [3:0] pf;
    logic [3:0] nf;
  } vec_t;

  vec_t vecs[$];
  int   applied     = 0;
  int   miscompares = 0;

  task automatic add(input int n, input logic rst, input logic [3:0] noisy,
                     input logic [3:0] clr, input logic [3:0] cond,
                     input logic [3:0] pos, input logic [3:0] neg,
                     input logic [3:0] pf, input logic [3:0] nf);
    vec_t v;
    v.n = n; v.rst = rst; v.noisy = noisy; v.clr = clr; v.cond = cond;
    v.pos = pos; v.neg = neg; v.pf = pf; v.nf = nf;
    vecs.push_back(v);
  endtask

  initial begin
    int   k;
    logic exp_any;

    rst_a = 1'b1; noisy_a = '0; clr_a = '0;
    rst_b = 1'b1; noisy_b = '0; clr_b = '0;

    //   n rst noisy    clr      cond     pos      neg      pflag    nflag
    add(2, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000); // reset
    // ch0 clean rise: first sample edge 3, conditioned at edge 8
    add(5, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(2, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    // ch1 3-cycle glitch is rejected
    add(3, 0, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(7, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    // ch1 4-cycle pulse is accepted, then its fall is accepted too
    add(4, 0, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add(1, 0, 4'b0001, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 4'b0001, 4'b0000);
    add(3, 0, 4'b0001, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 4'b0000);
    add(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0011, 4'b0000);
    add(3, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0011, 4'b0010);
    // ch2 bounce 1,0,1,1,0,1,1,1,1: one rise, 5 edges after the stable run starts
    add(1, 0, 4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0011, 4'b0010);
    add(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0011, 4'b0010);
    add(2, 0, 4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0011, 4'b0010);
    add(1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0011, 4'b0010);
    add(5, 0, 4'b0101, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0011, 4'b0010);
    add(1, 0, 4'b0101, 4'b0000, 4'b0101, 4'b0100, 4'b0000, 4'b0011, 4'b0010);
    add(2, 0, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0111, 4'b0010);
    // ch3 rise, fall, rise again with clear coinciding with the pulse
    add(5, 0, 4'b1101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b0111, 4'b0010);
    add(1, 0, 4'b1101, 4'b0000, 4'b1101, 4'b1000, 4'b0000, 4'b0111, 4'b0010);
    add(1, 0, 4'b1101, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b1111, 4'b0010);
    add(5, 0, 4'b0101, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b1111, 4'b0010);
    add(1, 0, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b1000, 4'b1111, 4'b0010);
    add(1, 0, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b1111, 4'b1010);
    add(5, 0, 4'b1101, 4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b1111, 4'b1010);
    add(1, 0, 4'b1101, 4'b0000, 4'b1101, 4'b1000, 4'b0000, 4'b1111, 4'b1010);
    add(1, 0, 4'b1101, 4'b1000, 4'b1101, 4'b0000, 4'b0000, 4'b1111, 4'b0010);
    add(1, 0, 4'b1101, 4'b1000, 4'b1101, 4'b0000, 4'b0000, 4'b0111, 4'b0010);
    add(1, 0, 4'b1101, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b0111, 4'b0010);
    add(1, 0, 4'b1101, 4'b0111, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    // ch0 falls; reset lands with its counter at 2, then held-high inputs re-rise
    add(4, 0, 4'b1100, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(2, 1, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(5, 0, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b1101, 4'b0000, 4'b1101, 4'b1101, 4'b0000, 4'b0000, 4'b0000);
    add(2, 0, 4'b1101, 4'b0000, 4'b1101, 4'b0000, 4'b0000, 4'b1101, 4'b0000);

    foreach (vecs[r]) begin
      for (int c = 0; c < vecs[r].n; c++) begin
        @(negedge clk);
        rst_a = vecs[r].rst; noisy_a = vecs[r].noisy; clr_a = vecs[r].clr;
        @(posedge clk); #1;
        exp_any = |(vecs[r].pos | vecs[r].neg);
        applied++;
        if ({cond_a, pe_a, ne_a, pf_a, nf_a, any_a} !==
            {vecs[r].cond, vecs[r].pos, vecs[r].neg, vecs[r].pf, vecs[r].nf, exp_any}) begin
          miscompares++;
          $display("FAIL row%0d cyc%0d: got cond=%b pos=%b neg=%b pflag=%b nflag=%b any=%b, want cond=%b pos=%b neg=%b pflag=%b nflag=%b any=%b",
                   r, c, cond_a, pe_a, ne_a, pf_a, nf_a, any_a,
                   vecs[r].cond, vecs[r].pos, vecs[r].neg, vecs[r].pf, vecs[r].nf, exp_any);
        end
      end
    end

    // 8 channels, WAITTIME=5: reset state, then all rise together after 8 edges.
    @(negedge clk); rst_b = 1'b1; noisy_b = '0;
    @(posedge clk); #1;
    applied++;
    if ({cond_b, pe_b, ne_b, pf_b, nf_b, any_b} !== 41'd0) begin
      miscompares++;
      $display("FAIL wide_reset: got cond=%h pos=%h neg=%h pflag=%h nflag=%h any=%b, want all 0",
               cond_b, pe_b, ne_b, pf_b, nf_b, any_b);
    end

    @(negedge clk); rst_b = 1'b0; noisy_b = 8'hFF;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (cond_b == 8'h00 && pe_b == 8'h00 && ne_b == 8'h00 && k < 20);
    applied++;
    if (k != 8 || cond_b !== 8'hFF || pe_b !== 8'hFF || ne_b !== 8'h00 || any_b !== 1'b1) begin
      miscompares++;
      $display("FAIL wide_rise: got edges=%0d cond=%h pos=%h neg=%h any=%b, want edges=8 cond=ff pos=ff neg=00 any=1",
               k, cond_b, pe_b, ne_b, any_b);
    end

    @(negedge clk); noisy_b = 8'h00;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (cond_b == 8'hFF && ne_b == 8'h00 && pe_b == 8'h00 && k < 20);
    applied++;
    if (k != 8 || cond_b !== 8'h00 || ne_b !== 8'hFF || pe_b !== 8'h00 || any_b !== 1'b1) begin
      miscompares++;
      $display("FAIL wide_fall: got edges=%0d cond=%h pos=%h neg=%h any=%b, want edges=8 cond=00 pos=00 neg=ff any=1",
               k, cond_b, pe_b, ne_b, any_b);
    end

    @(posedge clk); #1;
    applied++;
    if (pf_b !== 8'hFF || nf_b !== 8'hFF || pe_b !== 8'h00 || ne_b !== 8'h00 || any_b !== 1'b0) begin
      miscompares++;
      $display("FAIL wide_flags: got pflag=%h nflag=%h pos=%h neg=%h any=%b, want pflag=ff nflag=ff pos=00 neg=00 any=0",
               pf_b, nf_b, pe_b, ne_b, any_b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
